// File: rtl/dac_ctrl_pkg.sv
// Shared types, constants and frame builder for the DAC frame scheduler.
package dac_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_GAP,
        ST_ARB,
        ST_SEND
    } sched_state_e;

    localparam int          FRAME_BITS         = 32;
    localparam logic [3:0]  CMD_WR_UPD         = 4'h3;
    localparam logic [31:0] DEFAULT_SETUP_WORD = 32'h08000001;

    // Write-and-update frame: {pad, command, channel address, 12-bit code, don't-care byte}.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0]  ch,
                                                          input logic [11:0] sample);
        return {4'h0, CMD_WR_UPD, ch, sample, 8'h00};
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// MSB-first SPI word shifter: cs low for FRAME_BITS*CLK_DIV cycles, sclk rises mid-bit.
module dac_spi_shifter
    import dac_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [FRAME_BITS-1:0] word_i,
    output logic                  cs_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  done_o,
    output logic                  active_o
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam int               BIT_W    = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic                  active_q, active_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        if (load_i) begin
            active_d = 1'b1;
            shreg_d  = word_i;
            div_d    = DIV_LAST;
            bit_d    = BIT_LAST;
        end else if (active_q) begin
            if (div_q == '0) begin
                div_d   = DIV_LAST;
                shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                if (bit_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end else begin
                div_d = div_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
        end
    end

    // The divider counts down, so the upper half of its range is the sclk-low phase.
    assign cs_o     = ~active_q;
    assign sclk_o   = active_q && (div_q < DIV_HALF);
    assign mosi_o   = active_q & shreg_q[FRAME_BITS-1];
    assign done_o   = active_q && (div_q == '0) && (bit_q == '0);
    assign active_o = active_q;

endmodule

// File: rtl/dac_frame_scheduler.sv
// Shares one serial DAC link among NUM_CH requesters: setup word after reset/reinit,
// then round-robin grants, one write/update frame per grant.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | shifting SETUP_WORD out; init_done is low
// SEND  | shifting the captured channel frame out
// GAP   | cs high for GAP_CYC cycles between frames
// ARB   | reinit pending -> INIT, else grant a requester, else idle
module dac_frame_scheduler
    import dac_ctrl_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CLK_DIV    = 2,
    parameter int          GAP_CYC    = 2,
    parameter logic [31:0] SETUP_WORD = DEFAULT_SETUP_WORD
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [12*NUM_CH-1:0] din_i,
    output logic [NUM_CH-1:0]    ack_o,
    input  logic                 reinit_i,
    output logic                 init_done_o,
    output logic                 busy_o,
    output logic                 cs_o,
    output logic                 sclk_o,
    output logic                 mosi_o
);

    localparam int               RR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    sched_state_e          state_q, state_d;
    logic [RR_W-1:0]       rr_q, rr_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  reinit_pend_q, reinit_pend_d;
    logic                  init_done_q, init_done_d;

    logic                  gnt_found;
    logic [RR_W-1:0]       gnt_ch;
    logic [RR_W-1:0]       cand;
    logic                  sh_load;
    logic [FRAME_BITS-1:0] sh_word;
    logic                  sh_done;
    logic                  sh_active;

    // Round-robin search starting at rr_q, wrapping modulo NUM_CH.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = RR_W'((int'(rr_q) + k) % NUM_CH);
            if (!gnt_found && req_i[cand]) begin
                gnt_found = 1'b1;
                gnt_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        gap_d         = gap_q;
        init_done_d   = init_done_q;
        reinit_pend_d = reinit_pend_q | reinit_i;
        ack_o         = '0;
        busy_o        = 1'b1;
        sh_load       = 1'b0;
        sh_word       = SETUP_WORD;
        unique case (state_q)
            ST_INIT: begin
                if (!sh_active) begin
                    sh_load = 1'b1;
                end else if (sh_done) begin
                    state_d     = ST_GAP;
                    gap_d       = GAP_LAST;
                    init_done_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (sh_done) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LAST;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_ARB;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ST_ARB: begin
                if (reinit_pend_q) begin
                    state_d       = ST_INIT;
                    init_done_d   = 1'b0;
                    reinit_pend_d = reinit_i;
                end else if (gnt_found) begin
                    ack_o[gnt_ch] = 1'b1;
                    sh_load       = 1'b1;
                    sh_word       = build_frame(4'(gnt_ch),
                                                din_i[12*int'(gnt_ch) +: 12]);
                    rr_d          = RR_W'((int'(gnt_ch) + 1) % NUM_CH);
                    state_d       = ST_SEND;
                end else begin
                    busy_o = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_INIT;
            rr_q          <= '0;
            gap_q         <= '0;
            reinit_pend_q <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            gap_q         <= gap_d;
            reinit_pend_q <= reinit_pend_d;
            init_done_q   <= init_done_d;
        end
    end

    assign init_done_o = init_done_q;

    dac_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (sh_load),
        .word_i   (sh_word),
        .cs_o     (cs_o),
        .sclk_o   (sclk_o),
        .mosi_o   (mosi_o),
        .done_o   (sh_done),
        .active_o (sh_active)
    );

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Bench for dac_frame_scheduler: SPI frames are decoded from the pins and checked
// against a queue of expected words; grants are checked against a vector table.
module tb_dac_frame_scheduler;

    localparam int          NUM_CH  = 4;
    localparam int          CLK_DIV = 2;
    localparam int          GAP_CYC = 2;
    localparam logic [31:0] SETUP   = 32'h08000001;
    localparam int          PERIOD  = 1 + 32 * CLK_DIV + GAP_CYC;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_CH-1:0]    req;
    logic [12*NUM_CH-1:0] din;
    logic [NUM_CH-1:0]    ack;
    logic                 reinit;
    logic                 init_done;
    logic                 busy;
    logic                 cs;
    logic                 sclk;
    logic                 mosi;

    dac_frame_scheduler #(
        .NUM_CH     (NUM_CH),
        .CLK_DIV    (CLK_DIV),
        .GAP_CYC    (GAP_CYC),
        .SETUP_WORD (SETUP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .din_i       (din),
        .ack_o       (ack),
        .reinit_i    (reinit),
        .init_done_o (init_done),
        .busy_o      (busy),
        .cs_o        (cs),
        .sclk_o      (sclk),
        .mosi_o      (mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          frames_done = 0;
    int          ack_cnt[NUM_CH];
    logic [31:0] sb_q[$];
    logic [11:0] dins[NUM_CH];

    int          mon_bits = 0;
    int          mon_low = 0;
    logic [31:0] mon_shreg = '0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_frame(input int ch);
        logic [3:0] nib;
        nib = 4'(ch);
        return {4'h0, 4'h3, nib, dins[ch], 8'h00};
    endfunction

    always @(posedge clk) cyc++;

    // Pin-level frame decoder and grant monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_bits  = 0;
            mon_low   = 0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (cs === 1'b0) begin
                mon_low++;
                if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                    mon_shreg = {mon_shreg[30:0], mosi};
                    mon_bits++;
                end
            end
            if (cs === 1'b1 && prev_cs === 1'b0) begin
                check("frame_bits", 32'(mon_bits), 32);
                check("cs_low_cycles", 32'(mon_low), 32'(32 * CLK_DIV));
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got %08h expected no frame", mon_shreg);
                end else begin
                    check("frame_data", mon_shreg, sb_q.pop_front());
                end
                frames_done++;
                mon_bits = 0;
                mon_low  = 0;
            end
            if (ack !== '0) begin
                check("ack_onehot", 32'($countones(ack)), 1);
                for (int c = 0; c < NUM_CH; c++) if (ack[c]) ack_cnt[c]++;
            end
            prev_cs   = cs;
            prev_sclk = sclk;
        end
    end

    task automatic wait_ack(input logic [3:0] exp_mask, input string name, output int at_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (ack !== '0) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s: got no ack expected ack=%0h", name, exp_mask);
        end else begin
            check(name, 32'(ack), 32'(exp_mask));
        end
        at_cyc = cyc;
    endtask

    task automatic wait_frames(input int target, input string name);
        for (int i = 0; i < 1000 && frames_done < target; i++) @(negedge clk);
        if (frames_done < target) begin
            checks++;
            $display("FAIL %s: got %0d frames expected %0d", name, frames_done, target);
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 600 && !idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && cs === 1'b1) idle = 1'b1;
        end
        if (!idle) begin
            checks++;
            $display("FAIL %s: got busy=%0b expected idle", name, busy);
        end
    endtask

    task automatic drive_req(input logic [3:0] m);
        @(posedge clk);
        #1 req = m;
    endtask

    typedef struct {
        logic [3:0]  req;
        int          ch;
        logic [31:0] frame;
    } vec_t;

    vec_t vecs[7];
    int   t_ack[5];
    int   ord[5];
    int   t_tmp;
    int   fd;
    int   a_save;

    initial begin
        // Grants below follow the round-robin pointer left at 1 by the all-request burst.
        vecs[0] = '{4'b0100, 2, 32'h032ABC00};
        vecs[1] = '{4'b0011, 0, 32'h03012300};
        vecs[2] = '{4'b1001, 3, 32'h033FED00};
        vecs[3] = '{4'b1000, 3, 32'h033FED00};
        vecs[4] = '{4'b0001, 0, 32'h03012300};
        vecs[5] = '{4'b0110, 1, 32'h03145600};
        vecs[6] = '{4'b0001, 0, 32'h03012300};
        ord     = '{0, 1, 2, 3, 0};
        dins    = '{12'h123, 12'h456, 12'hABC, 12'hFED};
        for (int c = 0; c < NUM_CH; c++) ack_cnt[c] = 0;

        rst_n  = 1'b0;
        req    = '0;
        reinit = 1'b0;
        din    = {dins[3], dins[2], dins[1], dins[0]};
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs), 1);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_busy", 32'(busy), 1);

        // Setup word after reset release
        sb_q.push_back(SETUP);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_frames(1, "init_frame");
        wait_idle("init_idle");
        check("init_done_after_setup", 32'(init_done), 1);
        check("busy_idle", 32'(busy), 0);

        // All channels requesting: rotation order and frame period
        drive_req(4'b1111);
        for (int i = 0; i < 5; i++) sb_q.push_back(exp_frame(ord[i]));
        for (int i = 0; i < 5; i++) begin
            wait_ack(4'(1 << ord[i]), "rr_order", t_ack[i]);
            if (i > 0) check("frame_spacing", 32'(t_ack[i] - t_ack[i-1]), 32'(PERIOD));
        end
        @(posedge clk);
        #1 req = '0;
        wait_frames(6, "rr_frames");
        wait_idle("rr_idle");

        // Table of single grants
        for (int v = 0; v < 7; v++) begin
            fd = frames_done;
            drive_req(vecs[v].req);
            sb_q.push_back(vecs[v].frame);
            wait_ack(4'(1 << vecs[v].ch), "vec_ack", t_tmp);
            @(posedge clk);
            #1 req = '0;
            wait_frames(fd + 1, "vec_frame");
            wait_idle("vec_idle");
        end

        // Request pulsed only during SEND is never granted
        fd = frames_done;
        drive_req(4'b0001);
        sb_q.push_back(exp_frame(0));
        wait_ack(4'b0001, "pulse_setup_ack", t_tmp);
        @(posedge clk);
        #1 req = '0;
        a_save = ack_cnt[1];
        repeat (10) @(posedge clk);
        #1 req = 4'b0010;
        @(posedge clk);
        #1 req = '0;
        wait_frames(fd + 1, "pulse_frame");
        wait_idle("pulse_idle");
        repeat (10) @(negedge clk);
        check("pulse_no_ack_ch1", 32'(ack_cnt[1]), 32'(a_save));
        check("pulse_frame_count", 32'(frames_done), 32'(fd + 1));

        // Reinit during the ch1 frame while ch0 is requesting
        fd = frames_done;
        drive_req(4'b0010);
        sb_q.push_back(exp_frame(1));
        sb_q.push_back(SETUP);
        sb_q.push_back(exp_frame(0));
        wait_ack(4'b0010, "reinit_ch1_ack", t_tmp);
        @(posedge clk);
        #1 req = 4'b0001;
        a_save = ack_cnt[0];
        repeat (10) @(posedge clk);
        #1 reinit = 1'b1;
        @(posedge clk);
        #1 reinit = 1'b0;
        wait_frames(fd + 1, "reinit_ch1_frame");
        t_tmp = 0;
        for (int i = 0; i < 50 && t_tmp == 0; i++) begin
            @(negedge clk);
            if (cs === 1'b0) t_tmp = 1;
        end
        check("reinit_setup_start", 32'(t_tmp), 1);
        check("reinit_init_done_low", 32'(init_done), 0);
        check("reinit_no_early_ack", 32'(ack_cnt[0]), 32'(a_save));
        wait_ack(4'b0001, "reinit_then_ch0", t_tmp);
        check("reinit_init_done_high", 32'(init_done), 1);
        check("reinit_frames_before_ack", 32'(frames_done), 32'(fd + 2));
        @(posedge clk);
        #1 req = '0;
        wait_frames(fd + 3, "reinit_ch0_frame");
        wait_idle("reinit_idle");

        // Reset at bit 10 of a SEND frame
        drive_req(4'b0100);
        sb_q.push_back(exp_frame(2));
        wait_ack(4'b0100, "abort_ack", t_tmp);
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(cs), 1);
        check("abort_sclk", 32'(sclk), 0);
        check("abort_ack", 32'(ack), 0);
        check("abort_busy", 32'(busy), 1);
        check("abort_init_done", 32'(init_done), 0);
        sb_q.delete();
        sb_q.push_back(SETUP);
        sb_q.push_back(exp_frame(2));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fd = frames_done;
        wait_ack(4'b0100, "post_reset_ch2", t_tmp);
        check("setup_before_ack", 32'(frames_done), 32'(fd + 1));
        check("post_reset_init_done", 32'(init_done), 1);
        @(posedge clk);
        #1 req = '0;
        wait_frames(fd + 2, "post_reset_frame");
        wait_idle("post_reset_idle");
        check("scoreboard_empty", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
